// File: rtl/noc_sequencer_pkg.sv
// noc_sequencer_pkg: op codes, default sizes and FSM states for the NoC run controller
package noc_sequencer_pkg;
  localparam int DEF_NUM_ROUTERS = 4;
  localparam int DEF_RB_W = 2;
  localparam int DEF_OP_W = 4;
  localparam int DEF_CNT_W = 8;
  localparam int DEF_CYCLE_W = 16;
  localparam logic [DEF_OP_W-1:0] OP_NOP = 4'd0;
  localparam logic [DEF_OP_W-1:0] OP_INIT = 4'd1;
  localparam logic [DEF_OP_W-1:0] OP_LOAD_RT = 4'd2;
  localparam logic [DEF_OP_W-1:0] OP_LOAD_STAGING = 4'd3;
  localparam logic [DEF_OP_W-1:0] OP_PHASE0 = 4'd4;
  localparam logic [DEF_OP_W-1:0] OP_PHASE1 = 4'd5;
  localparam logic [DEF_OP_W-1:0] OP_FILL = 4'd6;
  localparam logic [DEF_OP_W-1:0] OP_DEQUEUE = 4'd7;
  typedef enum logic [3:0] {
    S_IDLE, S_INIT, S_LOAD_RT, S_FILL, S_LOAD_STAGING,
    S_INJ_REQ, S_INJ_LOAD, S_PHASE0, S_PHASE1, S_DONE
  } state_t;
endpackage

// File: rtl/noc_seq_src_ctr.sv
// noc_seq_src_ctr: remaining-entry counter for one traffic source
module noc_seq_src_ctr #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);
  logic [CNT_W-1:0] rem;
  // load the count on run start, count down once per fill issued
  always_ff @(posedge clk) begin
    if (rst) rem <= '0;
    else if (load) rem <= load_val;
    else if (dec && rem != '0) rem <= rem - 1'b1;
  end
  assign zero = rem == '0;
endmodule

// File: rtl/noc_sequencer.sv
// noc_sequencer: sequences routers and traffic sources through init, table load, fill and the per-cycle loop
module noc_sequencer
  import noc_sequencer_pkg::*;
#(
  parameter int NUM_ROUTERS = DEF_NUM_ROUTERS,
  parameter int RB_W = DEF_RB_W,
  parameter int OP_W = DEF_OP_W,
  parameter int CNT_W = DEF_CNT_W,
  parameter int CYCLE_W = DEF_CYCLE_W
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [CYCLE_W-1:0]          max_cycle,
  input  logic [NUM_ROUTERS*CNT_W-1:0] num_traffic,
  input  logic [NUM_ROUTERS-1:0]      rt_valid,
  input  logic [NUM_ROUTERS-1:0]      router_done,
  input  logic [NUM_ROUTERS-1:0]      traffic_empty,
  input  logic [NUM_ROUTERS-1:0]      can_inject,
  output logic [NUM_ROUTERS*OP_W-1:0] router_op,
  output logic [NUM_ROUTERS*OP_W-1:0] traffic_op,
  output logic [RB_W-1:0]             rt_dst,
  output logic [CNT_W-1:0]            fill_idx,
  output logic [NUM_ROUTERS-1:0]      inj_en,
  output logic [CYCLE_W-1:0]          in_cycle,
  output logic                        busy,
  output logic                        done,
  output logic                        timeout
);
  state_t state;
  logic [CYCLE_W-1:0] mc;
  logic [NUM_ROUTERS*OP_W-1:0] router_q;
  logic [NUM_ROUTERS-1:0] inj_mask, zero, fill_en;
  logic ld_rt, launch, go_fill, drained, last_cycle;

  function automatic logic [NUM_ROUTERS*OP_W-1:0] mop(input logic [NUM_ROUTERS-1:0] m, input logic [OP_W-1:0] op);
    mop = '0;
    for (int i = 0; i < NUM_ROUTERS; i++) mop[i*OP_W +: OP_W] = m[i] ? op : OP_NOP;
  endfunction

  // fill and loop-exit decisions
  always_comb begin
    launch = start && (state == S_IDLE || state == S_DONE);
    go_fill = (state == S_LOAD_RT && rt_dst == RB_W'(NUM_ROUTERS - 1)) || (state == S_FILL && !(&zero));
    fill_en = go_fill ? ~zero : '0;
    drained = &router_done && &traffic_empty;
    last_cycle = in_cycle + CYCLE_W'(1) == mc;
  end

  genvar g;
  generate
    for (g = 0; g < NUM_ROUTERS; g++) begin : g_src
      noc_seq_src_ctr #(.CNT_W(CNT_W)) u_ctr (
        .clk(clk),
        .rst(rst),
        .load(launch),
        .load_val(num_traffic[g*CNT_W +: CNT_W]),
        .dec(fill_en[g]),
        .zero(zero[g])
      );
      assign router_op[g*OP_W +: OP_W] = ld_rt && rt_valid[g] ? OP_LOAD_RT : router_q[g*OP_W +: OP_W];
    end
  endgenerate

  // run FSM; outputs are registered for the state being entered
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      router_q <= '0;
      traffic_op <= '0;
      rt_dst <= '0;
      fill_idx <= '0;
      inj_en <= '0;
      in_cycle <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      timeout <= 1'b0;
      mc <= '0;
      inj_mask <= '0;
      ld_rt <= 1'b0;
    end else begin
      router_q <= '0;
      traffic_op <= mop(fill_en, OP_FILL);
      inj_en <= '0;
      ld_rt <= 1'b0;
      case (state)
        S_IDLE, S_DONE: if (start) begin
          state <= S_INIT;
          router_q <= mop('1, OP_INIT);
          traffic_op <= mop('1, OP_INIT);
          busy <= 1'b1;
          done <= 1'b0;
          timeout <= 1'b0;
          in_cycle <= '0;
          mc <= max_cycle;
        end
        S_INIT: begin
          state <= S_LOAD_RT;
          rt_dst <= '0;
          ld_rt <= 1'b1;
        end
        S_LOAD_RT: if (rt_dst == RB_W'(NUM_ROUTERS - 1)) begin
          state <= S_FILL;
          rt_dst <= '0;
          fill_idx <= '0;
        end else begin
          rt_dst <= rt_dst + 1'b1;
          ld_rt <= 1'b1;
        end
        S_FILL: if (&zero) begin
          fill_idx <= '0;
          if (mc == '0) begin
            state <= S_DONE;
            busy <= 1'b0;
            done <= 1'b1;
            timeout <= 1'b1;
          end else begin
            state <= S_LOAD_STAGING;
            router_q <= mop('1, OP_LOAD_STAGING);
          end
        end else fill_idx <= fill_idx + 1'b1;
        S_LOAD_STAGING: begin
          state <= S_INJ_REQ;
          inj_mask <= ~traffic_empty & can_inject;
          traffic_op <= mop(~traffic_empty & can_inject, OP_DEQUEUE);
        end
        S_INJ_REQ: begin
          state <= S_INJ_LOAD;
          router_q <= mop(inj_mask, OP_DEQUEUE);
          inj_en <= inj_mask;
        end
        S_INJ_LOAD: begin
          state <= S_PHASE0;
          router_q <= mop('1, OP_PHASE0);
        end
        S_PHASE0: begin
          state <= S_PHASE1;
          router_q <= mop('1, OP_PHASE1);
        end
        S_PHASE1: begin
          in_cycle <= in_cycle + 1'b1;
          if (drained || last_cycle) begin
            state <= S_DONE;
            busy <= 1'b0;
            done <= 1'b1;
            timeout <= !drained;
          end else begin
            state <= S_LOAD_STAGING;
            router_q <= mop('1, OP_LOAD_STAGING);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
